// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch sequencer.
package fetch_pkg;

    localparam int ADDR_W_DEF = 6;
    localparam int INST_W_DEF = 32;
    localparam logic [31:0] NOP_INST = 32'h0007_8000;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        HALTED
    } fetch_state_t;

    typedef struct packed {
        logic [INST_W_DEF-1:0] data;
        logic [ADDR_W_DEF-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Instruction-memory and decode-handshake bundle between the fetch sequencer and its neighbours.
interface fetch_ctrl_if
    import fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int INST_W = INST_W_DEF
);
    logic [ADDR_W-1:0] imem_addr;
    logic [INST_W-1:0] imem_rdata;
    logic              inst_valid;
    logic              inst_ready;
    logic [INST_W-1:0] inst_data;
    logic [ADDR_W-1:0] inst_pc;

    modport master (
        output imem_addr,
        input  imem_rdata,
        output inst_valid,
        input  inst_ready,
        output inst_data,
        output inst_pc
    );

    modport slave (
        input  imem_addr,
        output imem_rdata,
        input  inst_valid,
        output inst_ready,
        input  inst_data,
        input  inst_pc
    );
endinterface

// File: rtl/fetch_skid_fifo.sv
// Two-entry skid FIFO with a registered head so decode sees flop outputs directly.
module fetch_skid_fifo
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic [1:0]   occ
);

    fetch_entry_t head_reg;
    fetch_entry_t tail_reg;
    logic [1:0]   occ_reg;

    // Entries shift toward the head; pop is only ever asserted with a valid head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_reg <= '0;
            tail_reg <= '0;
            occ_reg  <= 2'd0;
        end else if (flush) begin
            occ_reg <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (occ_reg == 2'd0) head_reg <= push_entry;
                    else                 tail_reg <= push_entry;
                    occ_reg <= occ_reg + 2'd1;
                end
                2'b01: begin
                    head_reg <= tail_reg;
                    occ_reg  <= occ_reg - 2'd1;
                end
                2'b11: begin
                    if (occ_reg == 2'd2) begin
                        head_reg <= tail_reg;
                        tail_reg <= push_entry;
                    end else begin
                        head_reg <= push_entry;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head       = head_reg;
    assign head_valid = (occ_reg != 2'd0);
    assign occ        = occ_reg;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: PC ownership, one-cycle memory latency tracking, redirect and halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int INST_W   = INST_W_DEF,
    parameter int RESET_PC = 0
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              halt_req,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              busy,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       fetch_count,
    output logic [15:0]       stall_count,
`endif
    fetch_ctrl_if.master      bus
);

    fetch_state_t      state_reg;
    logic [ADDR_W-1:0] imem_addr_reg;
    logic [ADDR_W-1:0] inflight_pc_reg;
    logic              inflight_reg;
    logic              busy_reg;

    fetch_entry_t      push_entry;
    fetch_entry_t      head;
    logic              head_valid;
    logic [1:0]        occ;
    logic              pop;
    logic              push;
    logic              issue;
    logic              run_start;
    logic [2:0]        pending;

    assign pop       = head_valid & bus.inst_ready;
    assign push      = inflight_reg & ~redirect_valid;
    // Words that will still be owned after this edge; issuing keeps the total within the FIFO depth.
    assign pending   = 3'(occ) + 3'(inflight_reg) - 3'(pop);
    assign issue     = (state_reg == RUN) & ~halt_req & ~redirect_valid & (pending < 3'd2);
    assign run_start = start & ~halt_req;

    assign push_entry.data = bus.imem_rdata;
    assign push_entry.pc   = inflight_pc_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            imem_addr_reg   <= ADDR_W'(RESET_PC);
            inflight_pc_reg <= '0;
            inflight_reg    <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            inflight_reg <= issue;
            if (issue) begin
                inflight_pc_reg <= imem_addr_reg;
                imem_addr_reg   <= imem_addr_reg + 1'b1;
            end
            case (state_reg)
                IDLE: if (run_start) begin
                    state_reg     <= RUN;
                    busy_reg      <= 1'b1;
                    imem_addr_reg <= ADDR_W'(RESET_PC);
                end
                RUN: if (halt_req) state_reg <= DRAIN;
                DRAIN: if (redirect_valid || (occ == 2'd0 && !inflight_reg)) begin
                    state_reg <= HALTED;
                    busy_reg  <= 1'b0;
                end
                HALTED: if (run_start) begin
                    state_reg <= RUN;
                    busy_reg  <= 1'b1;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
            // Redirect overrides any PC update made above.
            if (redirect_valid) imem_addr_reg <= redirect_pc;
        end
    end

    fetch_skid_fifo u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect_valid),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .head       (head),
        .head_valid (head_valid),
        .occ        (occ)
    );

    assign bus.imem_addr  = imem_addr_reg;
    assign bus.inst_valid = head_valid;
    assign bus.inst_data  = head.data;
    assign bus.inst_pc    = head.pc;
    assign busy           = busy_reg;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_reg <= 16'd0;
            stall_cnt_reg <= 16'd0;
        end else if (state_reg == IDLE && run_start) begin
            fetch_cnt_reg <= 16'd0;
            stall_cnt_reg <= 16'd0;
        end else begin
            if (pop && fetch_cnt_reg != 16'hFFFF)
                fetch_cnt_reg <= fetch_cnt_reg + 16'd1;
            if (head_valid && !bus.inst_ready && stall_cnt_reg != 16'hFFFF)
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign fetch_count = fetch_cnt_reg;
    assign stall_count = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: latency, backpressure, redirect, wrap, halt/resume and async reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        halt_req;
    logic        redirect_valid;
    logic [5:0]  redirect_pc;
    logic        busy;
    logic [31:0] mem [64];
    logic [31:0] rdata_q;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    fetch_ctrl_if #(.ADDR_W(6), .INST_W(32)) bus ();

    fetch_ctrl #(.ADDR_W(6), .INST_W(32), .RESET_PC(0)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .halt_req       (halt_req),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .busy           (busy),
`ifdef FETCH_PERF_CNT_EN
        .fetch_count    (fetch_count),
        .stall_count    (stall_count),
`endif
        .bus            (bus)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'(i);
    end

    // Synchronous memory: address captured on the edge, data visible the following cycle.
    always @(posedge clk) rdata_q <= mem[bus.imem_addr];
    assign bus.imem_rdata = rdata_q;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input string tag, input int pc);
        $display("inst %s: valid=%0b pc=%0d data=%08h", tag, bus.inst_valid, bus.inst_pc, bus.inst_data);
        check_eq({tag, "_valid"}, 64'(bus.inst_valid), 64'd1);
        check_eq({tag, "_pc"},    64'(bus.inst_pc),    64'(pc));
        check_eq({tag, "_data"},  64'(bus.inst_data),  64'(pc));
    endtask

    // Start in cycle C; RUN from C+1, first instruction visible in C+3.
    task automatic start_pulse(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check_eq({tag, "_busy_c1"},  64'(busy), 64'd1);
        check_eq({tag, "_valid_c1"}, 64'(bus.inst_valid), 64'd0);
        tick();
        check_eq({tag, "_valid_c2"}, 64'(bus.inst_valid), 64'd0);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        halt_req = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 6'd0;
        bus.inst_ready = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_eq("rst_valid", 64'(bus.inst_valid), 64'd0);
        check_eq("rst_data",  64'(bus.inst_data),  64'd0);
        check_eq("rst_pc",    64'(bus.inst_pc),    64'd0);
        check_eq("rst_busy",  64'(busy),           64'd0);
        check_eq("rst_addr",  64'(bus.imem_addr),  64'd0);
        rst_n = 1'b1;
        tick();

        // halt_req beats start in IDLE
        start = 1'b1;
        halt_req = 1'b1;
        tick();
        check_eq("halt_beats_start", 64'(busy), 64'd0);
        halt_req = 1'b0;

        // 1: latency and streaming
        bus.inst_ready = 1'b1;
        start_pulse("t1");
        for (int p = 0; p < 4; p++) begin
            if (p > 0) tick();
            expect_inst("t1", p);
        end

        // 2: backpressure while pc 3 is at the head
        bus.inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            expect_inst("t2_hold", 3);
            check_eq("t2_addr_frozen", 64'(bus.imem_addr), 64'd5);
        end
        tick();
        bus.inst_ready = 1'b1;
        for (int p = 3; p < 7; p++) begin
            if (p > 3) tick();
            expect_inst("t2_release", p);
        end

        // 3: redirect to 40 while FIFO holds 7,8
        tick();
        expect_inst("t3_pre", 7);
        bus.inst_ready = 1'b0;
        tick();
        expect_inst("t3_full", 7);
        redirect_valid = 1'b1;
        redirect_pc = 6'd40;
        tick();
        redirect_valid = 1'b0;
        bus.inst_ready = 1'b1;
        check_eq("t3_flush_valid", 64'(bus.inst_valid), 64'd0);
        check_eq("t3_addr",        64'(bus.imem_addr),  64'd40);
        tick();
        check_eq("t3_gap_valid",   64'(bus.inst_valid), 64'd0);
        tick();
        expect_inst("t3", 40);
        tick();
        expect_inst("t3", 41);

        // 4: redirect to 62 with a word in flight, then wrap
        redirect_valid = 1'b1;
        redirect_pc = 6'd62;
        tick();
        redirect_valid = 1'b0;
        check_eq("t4_flush_valid", 64'(bus.inst_valid), 64'd0);
        tick();
        check_eq("t4_gap_valid",   64'(bus.inst_valid), 64'd0);
        tick();
        expect_inst("t4", 62);
        tick();
        expect_inst("t4", 63);
        tick();
        expect_inst("t4", 0);
        tick();
        expect_inst("t4", 1);

        // 5: halt with FIFO full, drain, resume
        tick();
        expect_inst("t5_pre", 2);
        bus.inst_ready = 1'b0;
        tick();
        expect_inst("t5_full", 2);
        check_eq("t5_addr_full", 64'(bus.imem_addr), 64'd4);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        bus.inst_ready = 1'b1;
        check_eq("t5_busy_drain", 64'(busy), 64'd1);
        expect_inst("t5_drain", 2);
        tick();
        expect_inst("t5_drain", 3);
        tick();
        check_eq("t5_empty_valid", 64'(bus.inst_valid), 64'd0);
        check_eq("t5_busy_empty",  64'(busy), 64'd1);
        tick();
        check_eq("t5_busy_halted", 64'(busy), 64'd0);
        check_eq("t5_addr_halted", 64'(bus.imem_addr), 64'd4);
        tick();
        check_eq("t5_halted_valid", 64'(bus.inst_valid), 64'd0);
        start_pulse("t5_resume");
        expect_inst("t5_resume", 4);
        tick();
        expect_inst("t5_resume", 5);

        // 6: asynchronous reset between edges
        #3;
        rst_n = 1'b0;
        #1;
        check_eq("t6_valid", 64'(bus.inst_valid), 64'd0);
        check_eq("t6_busy",  64'(busy),           64'd0);
        check_eq("t6_addr",  64'(bus.imem_addr),  64'd0);
        check_eq("t6_pc",    64'(bus.inst_pc),    64'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check_eq("t6_idle_busy",  64'(busy),           64'd0);
        check_eq("t6_idle_valid", 64'(bus.inst_valid), 64'd0);
        start_pulse("t6_restart");
        expect_inst("t6_restart", 0);
        tick();
        expect_inst("t6_restart", 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
